// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple Adder slice per clock, LSB first,
// carry chained through a register, valid/ready handshakes on both sides.
module serial_nibble_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / 4;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [N-1:0][3:0] a_q, a_d;
    logic [N-1:0][3:0] b_q, b_d;
    logic [N-1:0][3:0] sum_q, sum_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [3:0]        a_sl;
    logic [3:0]        b_sl;
    logic [3:0]        add_sum;
    logic              add_cout;
    logic              last_slice;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign last_slice = (idx_q == IDX_W'(N - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)   state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  if (out_ready)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags follow the state being entered, so they register cleanly
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            S_IDLE:  in_ready_d  = 1'b1;
            S_DONE:  out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Slice select for the shared Adder
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_sl = a_q[k];
                b_sl = b_q[k];
            end
        end
    end

    Adder u_adder (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Datapath next-state: operand capture in IDLE, one slice per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                for (int k = 0; k < int'(N); k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (last_slice) begin
                    idx_d  = '0;
                    cout_d = add_cout;
                    // Carry into the MSB recovered from the MSB sum bit, xor carry out
                    ovf_d  = (a_q[N-1][3] ^ b_q[N-1][3] ^ add_sum[3]) ^ add_cout;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// 4-bit ripple-carry adder slice.
module Adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] c;

    always_comb begin
        Sum  = '0;
        c    = '0;
        c[0] = Cin;
        for (int k = 0; k < 4; k++) begin
            Sum[k]   = A[k] ^ B[k] ^ c[k];
            c[k+1]   = (A[k] & B[k]) | (c[k] & (A[k] ^ B[k]));
        end
        Cout = c[4];
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed self-checking bench for serial_nibble_adder at WIDTH=16.
module tb_serial_nibble_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int tests;
    int failed;
    int cyc_cnt;
    int acc_cnt;
    int last_acc;
    int prev_acc;

    serial_nibble_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept-edge bookkeeping for issue-period measurement
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n && in_valid && in_ready) begin
            acc_cnt  <= acc_cnt + 1;
            prev_acc <= last_acc;
            last_acc <= cyc_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        wait_out(tag, 4);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        tests = 0; failed = 0;
        cyc_cnt = 0; acc_cnt = 0; last_acc = 0; prev_acc = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic vectors
        do_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Back-pressure: result held while new operands wait
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("bp first", 4);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp held sum", 32'(sum), 32'h3333);
            check("bp held cout", 32'(cout), 32'd0);
            check("bp held overflow", 32'(overflow), 32'd0);
            check("bp held out_valid", 32'(out_valid), 32'd1);
            check("bp held in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp handshake in_ready", 32'(in_ready), 32'd1);
        check("bp handshake out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp pending accepted", 32'(in_ready), 32'd0);
        wait_out("bp second", 4);
        check("bp second sum", 32'(sum), 32'hAAAB);
        check("bp second cout", 32'(cout), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Minimum issue period with in_valid and out_ready held high
        @(negedge clk);
        n = acc_cnt;
        a = 16'h0001; b = 16'h0002; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 30 && acc_cnt < n + 2; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("period accepts", 32'(acc_cnt - n), 32'd2);
        check("period cycles", 32'(last_acc - prev_acc), 32'd6);
        repeat (8) @(posedge clk);
        #1;
        check("period sum", 32'(sum), 32'h0003);
        check("period idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset after two RUN slices
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid partial sum", 32'(sum), 32'h0055);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst sum", 32'(sum), 32'd0);
        check("mid rst cout", 32'(cout), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("mid rst no valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
